// File: rtl/cdb_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter.
package cdb_pkg;

    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;

    // Round-robin successor: wraps from n-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-producer result buffer: pointer-based FIFO with a wrap bit for full/empty.
// The head is read combinationally so a grant can pop and register it in one cycle.
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging NUM_SRC buffered producers onto one registered result bus.
// Optional synchronous flush input is enabled by defining CDB_FLUSH_EN.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef CDB_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]  cdb_src
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int EW    = TAG_W + DATA_W;

    logic [NUM_SRC-1:0] full, empty, push, pop;
    logic [EW-1:0]      head [NUM_SRC];
    logic               flush_i;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    logic               grant_found;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand_idx;
    int unsigned        cand;

`ifdef CDB_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign src_ready = ~full;
    assign push      = src_valid & src_ready;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
            cdb_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (EW)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (push[gi]),
                .pop   (pop[gi]),
                .flush (flush_i),
                .wdata ({src_tag[gi*TAG_W +: TAG_W], src_data[gi*DATA_W +: DATA_W]}),
                .full  (full[gi]),
                .empty (empty[gi]),
                .head  (head[gi])
            );
        end
    endgenerate

    // Eligibility uses registered emptiness, so same-cycle pushes are never granted.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_SRC) cand = cand - NUM_SRC;
            cand_idx = SRC_W'(cand);
            if (!grant_found && !empty[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        pop         = '0;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (grant_found) begin
            pop[grant_idx]            = 1'b1;
            rr_ptr_d                  = SRC_W'(rr_next(32'(grant_idx), NUM_SRC));
            cdb_valid_d               = 1'b1;
            {cdb_tag_d, cdb_data_d}   = head[grant_idx];
            cdb_src_d                 = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int NS = 3, TW = 4, DW = 32, DEPTH = 4, SW = 2, EW = TW + DW;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush_in = 1'b0;
    logic [NS-1:0]      src_valid = '0;
    logic [NS-1:0]      src_ready;
    logic [NS*TW-1:0]   src_tag = '0;
    logic [NS*DW-1:0]   src_data = '0;
    logic               cdb_valid;
    logic [TW-1:0]      cdb_tag;
    logic [DW-1:0]      cdb_data;
    logic [SW-1:0]      cdb_src;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel plus a round-robin start index.
    logic [EW-1:0] mq [NS][$];
    int            m_rr;
    logic          exp_valid;
    logic [TW-1:0] exp_tag;
    logic [DW-1:0] exp_data;
    logic [SW-1:0] exp_src;
    logic [NS-1:0] exp_ready;
    logic [NS-1:0] last_acc;

    cdb_arbiter #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CDB_FLUSH_EN
        .flush     (flush_in),
`endif
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_rr = 0;
        exp_valid = 1'b0;
        exp_tag = '0;
        exp_data = '0;
        exp_src = '0;
        exp_ready = '1;
    endtask

    task automatic do_reset();
        src_valid = '0;
        flush_in = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of offers, advance the model by one edge, and step the DUT.
    task automatic cycle(input logic [NS-1:0] v, input logic [NS*TW-1:0] t, input logic [NS*DW-1:0] d);
        int g;
        logic [EW-1:0] e;
        src_valid = v;
        src_tag = t;
        src_data = d;
        for (int i = 0; i < NS; i++) last_acc[i] = v[i] && (mq[i].size() < DEPTH);
        g = -1;
        for (int k = 0; k < NS; k++)
            if (g < 0 && mq[(m_rr + k) % NS].size() > 0) g = (m_rr + k) % NS;
        if (flush_in) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr = 0;
            exp_valid = 1'b0;
        end else begin
            if (g >= 0) begin
                e = mq[g].pop_front();
                exp_valid = 1'b1;
                exp_tag = e[EW-1:DW];
                exp_data = e[DW-1:0];
                exp_src = SW'(g);
                m_rr = (g + 1) % NS;
            end else begin
                exp_valid = 1'b0;
            end
            for (int i = 0; i < NS; i++)
                if (last_acc[i]) mq[i].push_back({t[i*TW +: TW], d[i*DW +: DW]});
        end
        for (int i = 0; i < NS; i++) exp_ready[i] = (mq[i].size() < DEPTH);
        @(posedge clk); #1;
        src_valid = '0;
        $display("t=%0t offer=%b acc=%b exp_bcast=%b src=%0d tag=%h data=%h", $time, v, last_acc,
                 exp_valid, exp_src, exp_tag, exp_data);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== '0 || src_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset: got v=%b tag=%h data=%h src=%0d rdy=%b, want all zero, rdy=111",
                     cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) cycle(3'b001, {4'd0, 4'd0, 4'd5}, {32'd0, 32'd0, 32'h11});
            else        cycle(3'b000, '0, '0);
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {exp_valid, exp_tag, exp_data, exp_src} ||
                src_ready !== exp_ready) begin
                errors++;
                $display("FAIL single c%0d: got v=%b tag=%h data=%h src=%0d rdy=%b want v=%b tag=%h data=%h src=%0d rdy=%b",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready,
                         exp_valid, exp_tag, exp_data, exp_src, exp_ready);
            end
        end
    endtask

    task automatic test_all_three();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) cycle(3'b111, {4'd3, 4'd2, 4'd1}, {32'hC3, 32'hB2, 32'hA1});
            else        cycle(3'b000, '0, '0);
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {exp_valid, exp_tag, exp_data, exp_src} ||
                src_ready !== exp_ready) begin
                errors++;
                $display("FAIL all_three c%0d: got v=%b tag=%h data=%h src=%0d rdy=%b want v=%b tag=%h data=%h src=%0d rdy=%b",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready,
                         exp_valid, exp_tag, exp_data, exp_src, exp_ready);
            end
        end
    endtask

    // All channels offer every cycle; ch1 holds its offer until accepted and carries a sequence.
    task automatic test_backpressure();
        int seq;
        int saw_full;
        seq = 0;
        saw_full = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            cycle(3'b111, {4'($urandom), 4'(seq), 4'($urandom)}, {$urandom, 32'(seq), $urandom});
            if (last_acc[1]) seq++;
            if (!src_ready[1]) saw_full++;
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {exp_valid, exp_tag, exp_data, exp_src} ||
                src_ready !== exp_ready) begin
                errors++;
                $display("FAIL backpressure c%0d: got v=%b tag=%h data=%h src=%0d rdy=%b want v=%b tag=%h data=%h src=%0d rdy=%b",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready,
                         exp_valid, exp_tag, exp_data, exp_src, exp_ready);
            end
        end
        checks++;
        if (saw_full == 0) begin
            errors++;
            $display("FAIL backpressure_full: src_ready[1] low cycles got %0d, want > 0", saw_full);
        end
    endtask

    // ch1 is granted first so the pointer sits at 2 when ch0 and ch2 become eligible.
    task automatic test_rr_wrap();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      cycle(3'b010, {4'd0, 4'd9, 4'd0}, {32'd0, 32'h99, 32'd0});
            else if (c == 1) cycle(3'b101, {4'd7, 4'd0, 4'd6}, {32'h77, 32'd0, 32'h66});
            else             cycle(3'b000, '0, '0);
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {exp_valid, exp_tag, exp_data, exp_src} ||
                src_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_wrap c%0d: got v=%b tag=%h data=%h src=%0d rdy=%b want v=%b tag=%h data=%h src=%0d rdy=%b",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready,
                         exp_valid, exp_tag, exp_data, exp_src, exp_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(3'b111, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1});
        cycle(3'b111, {4'd6, 4'd5, 4'd4}, {32'h6, 32'h5, 32'h4});
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== '0 || src_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_mid_async: got v=%b tag=%h data=%h src=%0d rdy=%b, want all zero, rdy=111",
                     cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 3) cycle(3'b110, {4'd8, 4'd7, 4'd0}, {32'h88, 32'h77, 32'h0});
            else        cycle(3'b000, '0, '0);
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {exp_valid, exp_tag, exp_data, exp_src} ||
                src_ready !== exp_ready) begin
                errors++;
                $display("FAIL reset_mid c%0d: got v=%b tag=%h data=%h src=%0d rdy=%b want v=%b tag=%h data=%h src=%0d rdy=%b",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready,
                         exp_valid, exp_tag, exp_data, exp_src, exp_ready);
            end
        end
    endtask

`ifdef CDB_FLUSH_EN
    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            flush_in = (c == 2);
            if (c < 2)       cycle(3'b101, {4'($urandom), 4'd0, 4'($urandom)}, {$urandom, 32'd0, $urandom});
            else if (c == 2) cycle(3'b010, {4'd0, 4'd4, 4'd0}, {32'd0, 32'h44, 32'd0});
            else             cycle(3'b000, '0, '0);
            flush_in = 1'b0;
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {exp_valid, exp_tag, exp_data, exp_src} ||
                src_ready !== exp_ready) begin
                errors++;
                $display("FAIL flush c%0d: got v=%b tag=%h data=%h src=%0d rdy=%b want v=%b tag=%h data=%h src=%0d rdy=%b",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready,
                         exp_valid, exp_tag, exp_data, exp_src, exp_ready);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            cycle(NS'($urandom), NS*TW'({$urandom}), {$urandom, $urandom, $urandom});
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {exp_valid, exp_tag, exp_data, exp_src} ||
                src_ready !== exp_ready) begin
                errors++;
                $display("FAIL random c%0d: got v=%b tag=%h data=%h src=%0d rdy=%b want v=%b tag=%h data=%h src=%0d rdy=%b",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_src, src_ready,
                         exp_valid, exp_tag, exp_data, exp_src, exp_ready);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_three();
        test_backpressure();
        test_rr_wrap();
        test_reset_mid();
`ifdef CDB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
